// File: rtl/replay_fifo_pkg.sv
// replay_fifo_pkg: shared helpers for the replay FIFO.
//   calc_aw   - RAM address width for a given depth
//   params_ok - legality of the parameter set (power-of-two depth >= 2,
//               read latency >= 1, almost-full threshold within depth)
// Pointer types depend on the instance depth, so each module declares
// ptr_t locally as logic [calc_aw(DEPTH):0].
package replay_fifo_pkg;

  function automatic int calc_aw(input int depth);
    return $clog2(depth);
  endfunction

  function automatic bit params_ok(input int depth, input int rd_lat, input int af);
    return (depth >= 2) && ((depth & (depth - 1)) == 0) &&
           (rd_lat >= 1) && (af >= 0) && (af <= depth);
  endfunction

endpackage

// File: rtl/replay_fifo_ram.sv
// replay_fifo_ram: simple dual-port storage, WIDTH x DEPTH.
//   clk, rst_n          - clock, sync active-low reset (read register only)
//   we, waddr, wdata    - write port
//   re, raddr, rdata    - synchronous read port, one cycle latency
// Contents are never reset so the array maps onto block RAM; only the
// output register clears.
module replay_fifo_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/replay_fifo.sv
// replay_fifo: single-clock FIFO with mark / rewind replay.
//   clk, rst_n             - clock, sync active-low reset
//   i_flush                - empty FIFO, drop mark, clear error flags
//   i_mark / i_rewind / i_release - set, return to, or drop the replay point
//   i_push, i_data, o_full, o_almost_full - write side
//   i_pop, o_empty, o_data, o_vld         - read side, o_vld RD_LATENCY after pop
//   o_count  - unread entries, o_held - entries pinned in storage
//   o_overflow / o_underflow - sticky error flags
module replay_fifo
  import replay_fifo_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 1024,
  parameter int RD_LATENCY = 3,
  parameter int AF_THRESH  = DEPTH - 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_mark,
  input  logic             i_rewind,
  input  logic             i_release,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_full,
  output logic             o_almost_full,
  input  logic             i_pop,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_data,
  output logic             o_vld,
  output logic [calc_aw(DEPTH):0] o_count,
  output logic [calc_aw(DEPTH):0] o_held,
  output logic             o_overflow,
  output logic             o_underflow
);

  localparam int AW     = calc_aw(DEPTH);
  localparam int STAGES = RD_LATENCY - 1;

  typedef logic [AW:0] ptr_t;

  localparam ptr_t DEPTH_P = ptr_t'(DEPTH);
  localparam ptr_t AF_P    = ptr_t'(AF_THRESH);
  localparam ptr_t ONE_P   = ptr_t'(1);

  if (!params_ok(DEPTH, RD_LATENCY, AF_THRESH)) begin : g_bad_params
    $error("replay_fifo: illegal DEPTH / RD_LATENCY / AF_THRESH");
  end

  ptr_t wptr, rptr, mptr;
  logic mark_active;
  ptr_t base;
  logic push_ok, pop_ok;

  // While a mark is active the storage floor is the mark, not the read
  // pointer, so replayable entries are never overwritten.
  assign base          = mark_active ? mptr : rptr;
  assign o_count       = wptr - rptr;
  assign o_held        = wptr - base;
  assign o_empty       = (wptr == rptr);
  assign o_full        = (o_held == DEPTH_P);
  assign o_almost_full = (o_held >= AF_P);

  assign push_ok = i_push & ~o_full & ~i_flush;
  assign pop_ok  = i_pop & ~o_empty & ~i_rewind & ~i_flush;

  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      wptr        <= '0;
      rptr        <= '0;
      mptr        <= '0;
      mark_active <= 1'b0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + ONE_P;
      // Rewind outranks mark/release; pop is already blocked by rewind.
      if (i_rewind) begin
        if (mark_active) rptr <= mptr;
      end else begin
        if (pop_ok) rptr <= rptr + ONE_P;
        if (i_mark) begin
          mptr        <= rptr + {{AW{1'b0}}, pop_ok};
          mark_active <= 1'b1;
        end else if (i_release) begin
          mark_active <= 1'b0;
        end
      end
      if (i_push & o_full)                o_overflow  <= 1'b1;
      if (i_pop & o_empty & ~i_rewind)    o_underflow <= 1'b1;
    end
  end

  logic [WIDTH-1:0] rdata;

  replay_fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (push_ok),
    .waddr (wptr[AW-1:0]),
    .wdata (i_data),
    .re    (pop_ok),
    .raddr (rptr[AW-1:0]),
    .rdata (rdata)
  );

  // vld_pipe[0] tracks the RAM output register; each further bit is one
  // extra output stage. Flush kills everything in flight.
  logic [STAGES:0] vld_pipe;

  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= pop_ok;
      for (int k = 1; k <= STAGES; k++) vld_pipe[k] <= vld_pipe[k-1];
    end
  end

  assign o_vld = vld_pipe[STAGES];

  if (STAGES == 0) begin : g_dq_none
    assign o_data = rdata;
  end else begin : g_dq
    logic [WIDTH-1:0] dq [1:STAGES];
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int k = 1; k <= STAGES; k++) dq[k] <= '0;
      end else begin
        dq[1] <= rdata;
        for (int k = 2; k <= STAGES; k++) dq[k] <= dq[k-1];
      end
    end
    assign o_data = dq[STAGES];
  end

endmodule

// File: tb/tb_replay_fifo.sv
module tb_replay_fifo;
  localparam int W = 16, D = 8, RL = 3, AF = 6;

  logic clk = 1'b0, rst_n;
  logic i_flush, i_mark, i_rewind, i_release, i_push, i_pop;
  logic [W-1:0] i_data, o_data;
  logic o_full, o_almost_full, o_empty, o_vld, o_overflow, o_underflow;
  logic [3:0] o_count, o_held;

  always #5 clk = ~clk;

  replay_fifo #(.WIDTH(W), .DEPTH(D), .RD_LATENCY(RL), .AF_THRESH(AF)) dut (
    .clk(clk), .rst_n(rst_n), .i_flush(i_flush), .i_mark(i_mark),
    .i_rewind(i_rewind), .i_release(i_release), .i_push(i_push),
    .i_data(i_data), .o_full(o_full), .o_almost_full(o_almost_full),
    .i_pop(i_pop), .o_empty(o_empty), .o_data(o_data), .o_vld(o_vld),
    .o_count(o_count), .o_held(o_held), .o_overflow(o_overflow),
    .o_underflow(o_underflow));

  int n_assert = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: unbounded absolute indices, a sparse store and a list
  // of reads that must emerge at a given cycle.
  typedef struct { int due; logic [W-1:0] d; } pend_t;
  pend_t pq[$];
  logic [W-1:0] store [int];
  logic [W-1:0] got[$];
  int w = 0, r = 0, m = 0, cyc = 0;
  bit mk = 0, ovf = 0, unf = 0, chk_en = 0;

  function automatic int m_held();
    return w - (mk ? m : r);
  endfunction

  task automatic model_step();
    int held, cnt;
    bit full, empty, pok;
    held = m_held(); cnt = w - r;
    full = (held == D); empty = (cnt == 0);
    if (!rst_n || i_flush) begin
      w = 0; r = 0; m = 0; mk = 0; ovf = 0; unf = 0; pq.delete();
    end else begin
      pok = i_pop && !empty && !i_rewind;
      if (i_push && full) ovf = 1;
      if (i_pop && empty && !i_rewind) unf = 1;
      if (pok) pq.push_back('{cyc + RL, store[r]});
      if (i_push && !full) begin store[w] = i_data; w++; end
      if (i_rewind) begin
        if (mk) r = m;
      end else begin
        if (pok) r++;
        if (i_mark) begin m = r; mk = 1; end
        else if (i_release) mk = 0;
      end
    end
  endtask

  // Single compare process, mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      bit ev;
      int held;
      held = m_held();
      ev = (pq.size() > 0) && (pq[0].due == cyc);
      chk("count", 32'(o_count), 32'(w - r));
      chk("held", 32'(o_held), 32'(held));
      chk("empty", 32'(o_empty), 32'(w == r));
      chk("full", 32'(o_full), 32'(held == D));
      chk("almost_full", 32'(o_almost_full), 32'(held >= AF));
      chk("overflow", 32'(o_overflow), 32'(ovf));
      chk("underflow", 32'(o_underflow), 32'(unf));
      chk("vld", 32'(o_vld), 32'(ev));
      if (o_vld) got.push_back(o_data);
      if (ev) begin
        chk("data", 32'(o_data), 32'(pq[0].d));
        void'(pq.pop_front());
      end
    end
  end

  task automatic idle_in();
    i_flush = 0; i_mark = 0; i_rewind = 0; i_release = 0;
    i_push = 0; i_pop = 0; i_data = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    idle_in();
  endtask

  task automatic push1(input logic [W-1:0] d);
    i_push = 1; i_data = d; tick();
  endtask

  task automatic pop1();
    i_pop = 1; tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst_n = 0; idle_in();
    idle(2);
    rst_n = 1;
    chk_en = 1;
    chk("rst_empty", 32'(o_empty), 32'd1);
    chk("rst_count", 32'(o_count), 32'd0);
    chk("rst_vld", 32'(o_vld), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);

    // 1: fill, overflow, drain
    for (int i = 1; i <= 8; i++) begin
      push1(16'(i));
      if (i == 5) chk("t1_af_low", 32'(o_almost_full), 32'd0);
      if (i == 6) chk("t1_af_high", 32'(o_almost_full), 32'd1);
    end
    chk("t1_full", 32'(o_full), 32'd1);
    push1(16'h0009);
    chk("t1_ovf", 32'(o_overflow), 32'd1);
    chk("t1_count", 32'(o_count), 32'd8);
    got.delete();
    for (int i = 0; i < 8; i++) pop1();
    idle(4);
    chk("t1_ngot", 32'(got.size()), 32'd8);
    for (int i = 0; i < 8 && i < got.size(); i++) chk("t1_data", 32'(got[i]), 32'(i + 1));
    chk("t1_empty", 32'(o_empty), 32'd1);

    // 2: mark / rewind replay
    i_flush = 1; tick();
    got.delete();
    for (int i = 0; i < 4; i++) push1(16'(16'hA0 + i));
    pop1();
    i_mark = 1; tick();
    for (int i = 0; i < 3; i++) pop1();
    i_rewind = 1; tick();
    chk("t2_count_rew", 32'(o_count), 32'd3);
    for (int i = 0; i < 3; i++) pop1();
    idle(4);
    chk("t2_ngot", 32'(got.size()), 32'd7);
    for (int i = 4; i < 7 && i < got.size(); i++) chk("t2_replay", 32'(got[i]), 32'(16'hA0 + i - 3));

    // 3: mark protection and release
    i_flush = 1; tick();
    i_mark = 1; tick();
    for (int i = 0; i < 8; i++) push1(16'(16'h30 + i));
    for (int i = 0; i < 8; i++) pop1();
    idle(4);
    push1(16'h0099);
    chk("t3_full", 32'(o_full), 32'd1);
    chk("t3_held", 32'(o_held), 32'd8);
    chk("t3_count", 32'(o_count), 32'd0);
    i_release = 1; tick();
    chk("t3_full_rel", 32'(o_full), 32'd0);
    push1(16'h0055);
    chk("t3_count_push", 32'(o_count), 32'd1);

    // 4: steady push+pop across wraps
    i_flush = 1; tick();
    got.delete();
    for (int i = 0; i < 4; i++) push1(16'(16'h40 + i));
    for (int i = 0; i < 30; i++) begin
      i_push = 1; i_pop = 1; i_data = 16'(16'h44 + i); tick();
      chk("t4_count", 32'(o_count), 32'd4);
    end
    for (int i = 0; i < 4; i++) pop1();
    idle(4);
    chk("t4_ngot", 32'(got.size()), 32'd34);
    for (int i = 0; i < got.size(); i++) chk("t4_order", 32'(got[i]), 32'(16'h40 + i));

    // 5: flush kills in-flight pops
    pop1();
    for (int i = 0; i < 3; i++) push1(16'(16'h50 + i));
    i_mark = 1; tick();
    got.delete();
    pop1(); pop1();
    i_flush = 1; tick();
    idle(5);
    chk("t5_ngot", 32'(got.size()), 32'd0);
    chk("t5_empty", 32'(o_empty), 32'd1);
    chk("t5_unf", 32'(o_underflow), 32'd0);
    push1(16'h0057); pop1(); idle(4);
    chk("t5_held", 32'(o_held), 32'd0);

    // 6: underflow, rewind without mark, mark+rewind
    i_flush = 1; tick();
    got.delete();
    pop1(); idle(4);
    chk("t6_unf", 32'(o_underflow), 32'd1);
    chk("t6_novld", 32'(got.size()), 32'd0);
    for (int i = 1; i <= 3; i++) push1(16'(16'h60 + i));
    pop1();
    i_rewind = 1; tick();
    chk("t6_rew_nomark", 32'(o_count), 32'd2);
    i_mark = 1; tick();
    pop1();
    i_mark = 1; i_rewind = 1; tick();
    chk("t6_mr_count", 32'(o_count), 32'd2);
    chk("t6_mr_held", 32'(o_held), 32'd2);
    pop1(); pop1(); idle(4);
    chk("t6_ngot", 32'(got.size()), 32'd4);
    if (got.size() == 4) begin
      chk("t6_d2", 32'(got[2]), 32'h62);
      chk("t6_d3", 32'(got[3]), 32'h63);
    end

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rst_n     = ($urandom_range(0, 299) != 0);
      i_flush   = ($urandom_range(0, 99) == 0);
      i_push    = ($urandom_range(0, 99) < 55);
      i_pop     = ($urandom_range(0, 99) < 50);
      i_mark    = ($urandom_range(0, 99) < 5);
      i_rewind  = ($urandom_range(0, 99) < 4);
      i_release = ($urandom_range(0, 99) < 4);
      i_data    = 16'($urandom);
      tick();
      rst_n = 1;
    end
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
